// File: rtl/preg_freelist_if.sv
// preg_freelist_if: allocate/free/squash bundle between rename, retire and the
// physical register free list.
//   slave  (free list): drives alloc_ready_o, alloc_preg_o, count_o, busy_o, err_o
//                       and samples alloc_valid_i, free_valid_i, free_preg_i, squash_i
//   master (pipeline) : the reverse directions
interface preg_freelist_if #(
  parameter int NPREG = 32,
  parameter int IDW   = $clog2(NPREG)
) ();
  logic           alloc_ready_o;
  logic           alloc_valid_i;
  logic [IDW-1:0] alloc_preg_o;
  logic           free_valid_i;
  logic [IDW-1:0] free_preg_i;
  logic           squash_i;
  logic [IDW:0]   count_o;
  logic           busy_o;
  logic           err_o;

  modport slave (
    output alloc_ready_o, alloc_preg_o, count_o, busy_o, err_o,
    input  alloc_valid_i, free_valid_i, free_preg_i, squash_i
  );

  modport master (
    input  alloc_ready_o, alloc_preg_o, count_o, busy_o, err_o,
    output alloc_valid_i, free_valid_i, free_preg_i, squash_i
  );
endinterface

// File: rtl/preg_freelist.sv
// preg_freelist: circular free list of physical register ids.
//   clk   : clock
//   rstn  : asynchronous active-low reset
//   bus   : preg_freelist_if.slave
//     alloc_ready_o/alloc_valid_i/alloc_preg_o : pop one id per cycle at head
//     free_valid_i/free_preg_i                 : push a retired id at tail
//     squash_i                                 : rebuild list (all ids free)
//     count_o                                  : number of free ids (registered)
//     busy_o                                   : sequential refill in progress
//     err_o                                    : sticky, free pushed while full
// After reset and after every squash the INIT walk writes list[i]=i for
// i=0..NPREG-1, one entry per cycle, then the list runs full.
module preg_freelist #(
  parameter int NPREG = 32
) (
  input  logic            clk,
  input  logic            rstn,
  preg_freelist_if.slave  bus
);
  localparam int IDW = $clog2(NPREG);

  localparam logic [IDW:0]   CNT_FULL = (IDW+1)'(NPREG);
  localparam logic [IDW:0]   CNT_LAST = (IDW+1)'(NPREG - 1);
  localparam logic [IDW:0]   CNT_ONE  = (IDW+1)'(1);
  localparam logic [IDW:0]   CNT_ZERO = (IDW+1)'(0);
  localparam logic [IDW-1:0] ID_ONE   = IDW'(1);
  localparam logic [IDW-1:0] ID_ZERO  = IDW'(0);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] list_q [NPREG];
  logic [IDW-1:0] head_q;
  logic [IDW-1:0] tail_q;
  logic [IDW:0]   count_q;
  logic [IDW:0]   init_idx_q;
  logic           err_q;

  logic           in_run;
  logic           pop;
  logic           push;
  logic           overflow;
  logic           init_write;

  // Event decode; squash masks every other event in its cycle.
  always_comb begin
    in_run     = (state_q == ST_RUN);
    pop        = in_run && !bus.squash_i && bus.alloc_valid_i && (count_q != CNT_ZERO);
    push       = in_run && !bus.squash_i && bus.free_valid_i  && (count_q != CNT_FULL);
    overflow   = in_run && !bus.squash_i && bus.free_valid_i  && (count_q == CNT_FULL);
    init_write = (state_q == ST_INIT) && !bus.squash_i;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: leave INIT once the last id has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (bus.squash_i) begin
          state_d = ST_INIT;
        end else if (init_idx_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (bus.squash_i) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Pointers, occupancy, walk index and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q     <= ID_ZERO;
      tail_q     <= ID_ZERO;
      count_q    <= CNT_ZERO;
      init_idx_q <= CNT_ZERO;
      err_q      <= 1'b0;
    end else if (bus.squash_i) begin
      head_q     <= ID_ZERO;
      tail_q     <= ID_ZERO;
      count_q    <= CNT_ZERO;
      init_idx_q <= CNT_ZERO;
    end else if (state_q == ST_INIT) begin
      init_idx_q <= init_idx_q + CNT_ONE;
      if (init_idx_q == CNT_LAST) begin
        head_q  <= ID_ZERO;
        tail_q  <= ID_ZERO;
        count_q <= CNT_FULL;
      end
    end else begin
      if (pop) begin
        head_q <= head_q + ID_ONE;
      end
      if (push) begin
        tail_q <= tail_q + ID_ONE;
      end
      case ({pop, push})
        2'b10:   count_q <= count_q - CNT_ONE;
        2'b01:   count_q <= count_q + CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (overflow) begin
        err_q <= 1'b1;
      end
    end
  end

  // List storage: the INIT walk writes identity ids, RUN writes freed ids at tail.
  always_ff @(posedge clk) begin
    if (init_write) begin
      list_q[init_idx_q[IDW-1:0]] <= init_idx_q[IDW-1:0];
    end else if (push) begin
      list_q[tail_q] <= bus.free_preg_i;
    end
  end

  // FSM outputs; ready depends only on registered state so a free into an
  // empty list is first grantable on the following cycle.
  always_comb begin
    bus.busy_o        = (state_q == ST_INIT);
    bus.alloc_ready_o = in_run && (count_q != CNT_ZERO);
    bus.alloc_preg_o  = list_q[head_q];
    bus.count_o       = count_q;
    bus.err_o         = err_q;
  end
endmodule

// File: tb/tb_preg_freelist.sv
// Directed bench for preg_freelist with a FIFO scoreboard of expected ids.
module tb_preg_freelist;
  localparam int NPREG = 32;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int unsigned q[$];

  preg_freelist_if #(.NPREG(NPREG)) bus ();

  preg_freelist #(.NPREG(NPREG)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i = 1'b0;
    bus.free_valid_i  = 1'b0;
    bus.free_preg_i   = '0;
    bus.squash_i      = 1'b0;
  endtask

  // Count cycles with busy_o high (bounded) and rebuild the expected list.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 100) begin
      chk({tag, "_ready_low"}, 32'(bus.alloc_ready_o), 32'd0);
      n++;
      step();
    end
    chk({tag, "_len"}, 32'(n), 32'(NPREG));
    q.delete();
    for (int i = 0; i < NPREG; i++) q.push_back(i);
    chk({tag, "_count"}, 32'(bus.count_o), 32'(q.size()));
    chk({tag, "_head"}, 32'(bus.alloc_preg_o), q[0]);
    chk({tag, "_ready"}, 32'(bus.alloc_ready_o), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    idle_inputs();
    step();
    step();
    chk("rst_busy", 32'(bus.busy_o), 32'd1);
    chk("rst_ready", 32'(bus.alloc_ready_o), 32'd0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    rstn = 1'b1;
    wait_init("init");

    // Drain the full list: ids in order 0..31.
    bus.alloc_valid_i = 1'b1;
    for (int i = 0; i < NPREG; i++) begin
      chk("drain_ready", 32'(bus.alloc_ready_o), 32'd1);
      chk("drain_id", 32'(bus.alloc_preg_o), q.pop_front());
      step();
    end
    chk("empty_ready", 32'(bus.alloc_ready_o), 32'd0);
    chk("empty_count", 32'(bus.count_o), 32'd0);
    step();
    chk("empty_hold_count", 32'(bus.count_o), 32'd0);
    bus.alloc_valid_i = 1'b0;

    // Free 5 into empty list: no bypass.
    bus.free_valid_i = 1'b1;
    bus.free_preg_i  = 5'd5;
    q.push_back(5);
    chk("nobypass_ready", 32'(bus.alloc_ready_o), 32'd0);
    step();
    bus.free_valid_i = 1'b0;
    chk("free5_ready", 32'(bus.alloc_ready_o), 32'd1);
    chk("free5_id", 32'(bus.alloc_preg_o), q[0]);
    chk("free5_count", 32'(bus.count_o), 32'(q.size()));

    // Simultaneous alloc of 5 and free of 9.
    chk("pair_grant", 32'(bus.alloc_preg_o), q.pop_front());
    bus.alloc_valid_i = 1'b1;
    bus.free_valid_i  = 1'b1;
    bus.free_preg_i   = 5'd9;
    q.push_back(9);
    step();
    idle_inputs();
    chk("pair_count", 32'(bus.count_o), 32'd1);
    chk("pair_next", 32'(bus.alloc_preg_o), q[0]);

    // 40 alloc/free pairs across the index wrap.
    for (int i = 0; i < 40; i++) begin
      logic [4:0] id;
      id = 5'($urandom_range(0, NPREG - 1));
      chk("wrap_id", 32'(bus.alloc_preg_o), q.pop_front());
      chk("wrap_count", 32'(bus.count_o), 32'(q.size() + 1));
      bus.alloc_valid_i = 1'b1;
      bus.free_valid_i  = 1'b1;
      bus.free_preg_i   = id;
      q.push_back(32'(id));
      step();
    end
    idle_inputs();
    while (q.size() > 0) begin
      chk("wrap_drain_id", 32'(bus.alloc_preg_o), q.pop_front());
      bus.alloc_valid_i = 1'b1;
      step();
    end
    bus.alloc_valid_i = 1'b0;
    chk("wrap_empty", 32'(bus.count_o), 32'd0);

    // Fill with 7 ids, then squash with alloc/free in the same cycle.
    for (int i = 0; i < 7; i++) begin
      bus.free_valid_i = 1'b1;
      bus.free_preg_i  = 5'(10 + i);
      q.push_back(10 + i);
      step();
    end
    idle_inputs();
    chk("sq_pre_count", 32'(bus.count_o), 32'd7);
    chk("sq_pre_id", 32'(bus.alloc_preg_o), q[0]);
    bus.squash_i      = 1'b1;
    bus.alloc_valid_i = 1'b1;
    bus.free_valid_i  = 1'b1;
    bus.free_preg_i   = 5'd3;
    step();
    idle_inputs();
    chk("sq_busy", 32'(bus.busy_o), 32'd1);
    chk("sq_count", 32'(bus.count_o), 32'd0);
    wait_init("sq_init");

    // Squash at init cycle 10; frees during INIT are ignored without error.
    bus.squash_i = 1'b1;
    step();
    bus.squash_i     = 1'b0;
    bus.free_valid_i = 1'b1;
    bus.free_preg_i  = 5'd7;
    bus.alloc_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("init_busy", 32'(bus.busy_o), 32'd1);
      chk("init_count", 32'(bus.count_o), 32'd0);
      step();
    end
    idle_inputs();
    chk("init_noerr", 32'(bus.err_o), 32'd0);
    bus.squash_i = 1'b1;
    step();
    bus.squash_i = 1'b0;
    wait_init("resq_init");

    // Free while full: sticky error, no change in count or contents.
    bus.free_valid_i = 1'b1;
    bus.free_preg_i  = 5'd3;
    step();
    idle_inputs();
    chk("ovf_err", 32'(bus.err_o), 32'd1);
    chk("ovf_count", 32'(bus.count_o), 32'(NPREG));
    chk("ovf_head", 32'(bus.alloc_preg_o), q[0]);
    step();
    step();
    chk("ovf_sticky", 32'(bus.err_o), 32'd1);
    bus.squash_i = 1'b1;
    step();
    bus.squash_i = 1'b0;
    wait_init("ovf_init");
    chk("ovf_sticky_sq", 32'(bus.err_o), 32'd1);

    // Reset clears the error.
    rstn = 1'b0;
    #1;
    chk("rst2_err", 32'(bus.err_o), 32'd0);
    chk("rst2_busy", 32'(bus.busy_o), 32'd1);
    chk("rst2_count", 32'(bus.count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
